// File: rtl/pipe_ctrl_unit.sv
// Control unit for a 5-stage MIPS pipeline: ID decode, ID/EX -> EX/MEM -> MEM/WB
// control propagation, load-use bubble, taken-branch flush and multi-cycle multiply stall.
module pipe_ctrl_unit #(
  parameter int OPW         = 6,
  parameter int REGW        = 5,
  parameter int MUL_LATENCY = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OPW-1:0]  opcode_id,
  input  logic [REGW-1:0] rs_id,
  input  logic [REGW-1:0] rt_id,
  input  logic [REGW-1:0] rd_id,
  input  logic            branch_taken_ex,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            ifid_flush,
  output logic            stall,
  output logic            ex_regDst,
  output logic            ex_ALUsrc,
  output logic [OPW-1:0]  ex_opcode,
  output logic            ex_branch,
  output logic            mem_memRead,
  output logic            mem_memWrite,
  output logic            wb_regWrite,
  output logic            wb_memToReg,
  output logic [REGW-1:0] wb_dest,
  output logic            mul_busy
);

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_MUL   = OPW'(6'b011100);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_ORI   = OPW'(6'b001101);
  localparam logic [OPW-1:0] OP_LUI   = OPW'(6'b001111);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);

  localparam int              CNTW     = $clog2(MUL_LATENCY) + 1;
  localparam logic [CNTW-1:0] MUL_LOAD = CNTW'(MUL_LATENCY - 1);

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic reg_dst;
    logic alu_src;
  } ctrl_t;

  typedef struct packed {
    ctrl_t           ctrl;
    logic [OPW-1:0]  opcode;
    logic [REGW-1:0] dest;
  } idex_t;

  typedef struct packed {
    logic            reg_write;
    logic            mem_to_reg;
    logic            mem_read;
    logic            mem_write;
    logic [REGW-1:0] dest;
  } exmem_t;

  typedef struct packed {
    logic            reg_write;
    logic            mem_to_reg;
    logic [REGW-1:0] dest;
  } memwb_t;

  idex_t           r_idex;
  exmem_t          r_exmem;
  memwb_t          r_memwb;
  logic [CNTW-1:0] r_mul_cnt;

  ctrl_t           w_ctrl;
  logic [REGW-1:0] w_dest;
  idex_t           w_idex_dec;
  logic            w_uses_rt;
  logic            w_mul_busy;
  logic            w_flush;
  logic            w_load_use;
  logic            w_stall;
  logic            w_capture;

  // A zero destination can never be written, so regWrite is dropped at capture.
  always_comb begin
    w_ctrl = '0;
    case (opcode_id)
      OP_RTYPE, OP_MUL: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = 1'b1;
      end
      OP_ADDI, OP_ORI, OP_LUI: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
      end
      OP_BEQ, OP_BNE: w_ctrl.branch = 1'b1;
      OP_LW: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.mem_read   = 1'b1;
        w_ctrl.alu_src    = 1'b1;
      end
      OP_SW: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
      end
      default: ;
    endcase
    w_dest = w_ctrl.reg_dst ? rd_id : rt_id;
    if (w_dest == '0) w_ctrl.reg_write = 1'b0;
    w_idex_dec = '{ctrl: w_ctrl, opcode: opcode_id, dest: w_dest};
  end

  assign w_uses_rt = (opcode_id == OP_RTYPE) | (opcode_id == OP_MUL) |
                     (opcode_id == OP_BEQ)   | (opcode_id == OP_BNE) |
                     (opcode_id == OP_SW);

  // Priority: multiply hold, then taken-branch flush, then load-use.
  assign w_mul_busy = (r_mul_cnt != '0);
  assign w_flush    = ~w_mul_busy & r_idex.ctrl.branch & branch_taken_ex;
  assign w_load_use = ~w_mul_busy & ~w_flush & r_idex.ctrl.mem_read &
                      (r_idex.dest != '0) &
                      ((r_idex.dest == rs_id) | (w_uses_rt & (r_idex.dest == rt_id)));
  assign w_stall    = w_mul_busy | w_load_use;
  assign w_capture  = ~w_mul_busy & ~w_flush & ~w_load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idex    <= '0;
      r_exmem   <= '0;
      r_memwb   <= '0;
      r_mul_cnt <= '0;
    end else begin
      if (w_mul_busy)     r_idex <= r_idex;
      else if (w_capture) r_idex <= w_idex_dec;
      else                r_idex <= '0;

      // The counter is armed as a multiply enters EX; it covers the extra EX cycles.
      if (w_mul_busy)                            r_mul_cnt <= r_mul_cnt - 1'b1;
      else if (w_capture && opcode_id == OP_MUL) r_mul_cnt <= MUL_LOAD;
      else                                       r_mul_cnt <= '0;

      if (w_mul_busy) r_exmem <= '0;
      else            r_exmem <= '{reg_write:  r_idex.ctrl.reg_write,
                                   mem_to_reg: r_idex.ctrl.mem_to_reg,
                                   mem_read:   r_idex.ctrl.mem_read,
                                   mem_write:  r_idex.ctrl.mem_write,
                                   dest:       r_idex.dest};

      r_memwb <= '{reg_write:  r_exmem.reg_write,
                   mem_to_reg: r_exmem.mem_to_reg,
                   dest:       r_exmem.dest};
    end
  end

  assign stall        = w_stall;
  assign pc_write     = ~w_stall;
  assign ifid_write   = ~w_stall;
  assign ifid_flush   = w_flush;
  assign mul_busy     = w_mul_busy;
  assign ex_regDst    = r_idex.ctrl.reg_dst;
  assign ex_ALUsrc    = r_idex.ctrl.alu_src;
  assign ex_opcode    = r_idex.opcode;
  assign ex_branch    = r_idex.ctrl.branch;
  assign mem_memRead  = r_exmem.mem_read;
  assign mem_memWrite = r_exmem.mem_write;
  assign wb_regWrite  = r_memwb.reg_write;
  assign wb_memToReg  = r_memwb.mem_to_reg;
  assign wb_dest      = r_memwb.dest;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: three instances (multiply latency 4, 1, 3) driven in lockstep,
// checked by a per-instruction pipeline model plus hand tables and corner sequences.
module tb_pipe_ctrl_unit;

  localparam logic [5:0] OP_R = 6'h00, OP_MUL = 6'h1c, OP_ADDI = 6'h08, OP_ORI = 6'h0d,
                         OP_LUI = 6'h0f, OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_LW = 6'h23,
                         OP_SW = 6'h2b, OP_NOP = 6'h3f;
  localparam logic [22:0] RST_VEC = {2'b11, 21'd0};

  logic       clk, rst_n;
  logic [5:0] opcode_id;
  logic [4:0] rs_id, rt_id, rd_id;
  logic       branch_taken_ex;

  logic [2:0] pc_write, ifid_write, ifid_flush, stall, ex_regDst, ex_ALUsrc, ex_branch;
  logic [2:0] mem_memRead, mem_memWrite, wb_regWrite, wb_memToReg, mul_busy;
  logic [5:0] ex_opcode [3];
  logic [4:0] wb_dest [3];
  logic [22:0] act [3];
  logic [22:0] snap [3];

  int n_tests = 0, n_fail = 0;

  pipe_ctrl_unit #(.MUL_LATENCY(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .opcode_id(opcode_id), .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
    .branch_taken_ex(branch_taken_ex), .pc_write(pc_write[0]), .ifid_write(ifid_write[0]),
    .ifid_flush(ifid_flush[0]), .stall(stall[0]), .ex_regDst(ex_regDst[0]), .ex_ALUsrc(ex_ALUsrc[0]),
    .ex_opcode(ex_opcode[0]), .ex_branch(ex_branch[0]), .mem_memRead(mem_memRead[0]),
    .mem_memWrite(mem_memWrite[0]), .wb_regWrite(wb_regWrite[0]), .wb_memToReg(wb_memToReg[0]),
    .wb_dest(wb_dest[0]), .mul_busy(mul_busy[0]));

  pipe_ctrl_unit #(.MUL_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .opcode_id(opcode_id), .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
    .branch_taken_ex(branch_taken_ex), .pc_write(pc_write[1]), .ifid_write(ifid_write[1]),
    .ifid_flush(ifid_flush[1]), .stall(stall[1]), .ex_regDst(ex_regDst[1]), .ex_ALUsrc(ex_ALUsrc[1]),
    .ex_opcode(ex_opcode[1]), .ex_branch(ex_branch[1]), .mem_memRead(mem_memRead[1]),
    .mem_memWrite(mem_memWrite[1]), .wb_regWrite(wb_regWrite[1]), .wb_memToReg(wb_memToReg[1]),
    .wb_dest(wb_dest[1]), .mul_busy(mul_busy[1]));

  pipe_ctrl_unit #(.MUL_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .opcode_id(opcode_id), .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
    .branch_taken_ex(branch_taken_ex), .pc_write(pc_write[2]), .ifid_write(ifid_write[2]),
    .ifid_flush(ifid_flush[2]), .stall(stall[2]), .ex_regDst(ex_regDst[2]), .ex_ALUsrc(ex_ALUsrc[2]),
    .ex_opcode(ex_opcode[2]), .ex_branch(ex_branch[2]), .mem_memRead(mem_memRead[2]),
    .mem_memWrite(mem_memWrite[2]), .wb_regWrite(wb_regWrite[2]), .wb_memToReg(wb_memToReg[2]),
    .wb_dest(wb_dest[2]), .mul_busy(mul_busy[2]));

  // Output bundle: [22]pc_write [21]ifid_write [20]flush [19]stall [18]regDst [17]ALUsrc
  // [16:11]ex_opcode [10]branch [9]memRead [8]memWrite [7]regWrite [6]memToReg [5:1]dest [0]busy
  for (genvar g = 0; g < 3; g++) begin : g_pack
    assign act[g] = {pc_write[g], ifid_write[g], ifid_flush[g], stall[g], ex_regDst[g], ex_ALUsrc[g],
                     ex_opcode[g], ex_branch[g], mem_memRead[g], mem_memWrite[g], wb_regWrite[g],
                     wb_memToReg[g], wb_dest[g], mul_busy[g]};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: one record per instruction slot ----------------
  typedef struct packed {
    logic rw, mtr, mr, mw, br, rdst, as;
    logic [5:0] op;
    logic [4:0] dest;
  } ins_t;

  ins_t m_ex [3], m_mem [3], m_wb [3];
  ins_t n_ex [3], n_mem [3], n_wb [3];
  int   m_age [3], n_age [3];
  logic m_stall [3];
  int   lat [3] = '{4, 1, 3};

  function automatic ins_t mdec(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd);
    ins_t x;
    x = '0;
    x.op = op;
    if (op == OP_R || op == OP_MUL) begin x.rw = 1; x.rdst = 1; end
    if (op == OP_ADDI || op == OP_ORI || op == OP_LUI) begin x.rw = 1; x.as = 1; end
    if (op == OP_BEQ || op == OP_BNE) x.br = 1;
    if (op == OP_LW) begin x.rw = 1; x.mtr = 1; x.mr = 1; x.as = 1; end
    if (op == OP_SW) begin x.mw = 1; x.as = 1; end
    x.dest = x.rdst ? rd : rt;
    if (x.dest == 0) x.rw = 0;
    return x;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; m_age[k] = 0; m_stall[k] = 0;
    end
  endtask

  task automatic model_eval(input int k, output logic [22:0] e);
    logic busy, flush, lu, st, usesrt;
    ins_t x;
    x = m_ex[k];
    busy   = (x.op == OP_MUL) && (m_age[k] < lat[k] - 1);
    flush  = !busy && x.br && branch_taken_ex;
    usesrt = opcode_id inside {OP_R, OP_MUL, OP_BEQ, OP_BNE, OP_SW};
    lu     = !busy && !flush && x.mr && x.dest != 0 &&
             (x.dest == rs_id || (usesrt && x.dest == rt_id));
    st     = busy || lu;
    e = {!st, !st, flush, st, x.rdst, x.as, x.op, x.br, m_mem[k].mr, m_mem[k].mw,
         m_wb[k].rw, m_wb[k].mtr, m_wb[k].dest, busy};
    m_stall[k] = st;
    n_wb[k]  = m_mem[k];
    n_mem[k] = busy ? '0 : x;
    if (busy) begin
      n_ex[k] = x; n_age[k] = m_age[k] + 1;
    end else begin
      n_ex[k] = (flush || lu) ? '0 : mdec(opcode_id, rt_id, rd_id);
      n_age[k] = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask

  // One cycle: drive ID, sample at negedge against the model, advance at posedge.
  task automatic step(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic bt);
    logic [22:0] e;
    opcode_id = op; rs_id = rs; rt_id = rt; rd_id = rd; branch_taken_ex = bt;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      snap[k] = act[k];
      model_eval(k, e);
      check($sformatf("model dut%0d op=%0h", k, op), 32'(act[k]), 32'(e));
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      m_ex[k] = n_ex[k]; m_mem[k] = n_mem[k]; m_wb[k] = n_wb[k]; m_age[k] = n_age[k];
    end
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge.
  task automatic async_reset(input string name);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) check($sformatf("%s dut%0d", name, k), 32'(act[k]), 32'(RST_VEC));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    logic [14:0] exp;  // {stall, ex_opcode, ex_regDst, mem_memRead, wb_regWrite, wb_dest}
  } row_t;

  function automatic row_t mkrow(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic st, input logic [5:0] eo,
                                 input logic rdst, input logic mr, input logic wr, input logic [4:0] wd);
    row_t r;
    r.op = op; r.rs = rs; r.rt = rt; r.rd = rd;
    r.exp = {st, eo, rdst, mr, wr, wd};
    return r;
  endfunction

  row_t tbl [13];
  logic [5:0] rops [10] = '{OP_R, OP_MUL, OP_ADDI, OP_ORI, OP_LUI, OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_NOP};

  initial begin
    int busy0, pclow0, busy1, busy3, arr0, arr1, phase;
    logic [4:0] wq [$];

    // LW $2 / ADD $3,$2,$4 with its bubble, then the no-hazard LW/ADDI and LW $0 cases
    tbl[0]  = mkrow(OP_LW,   5'd1, 5'd2, 5'd0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 5'd0);
    tbl[1]  = mkrow(OP_R,    5'd2, 5'd4, 5'd3, 1'b1, 6'h23, 1'b0, 1'b0, 1'b0, 5'd0);
    tbl[2]  = mkrow(OP_R,    5'd2, 5'd4, 5'd3, 1'b0, 6'h00, 1'b0, 1'b1, 1'b0, 5'd0);
    tbl[3]  = mkrow(OP_NOP,  5'd0, 5'd0, 5'd0, 1'b0, 6'h00, 1'b1, 1'b0, 1'b1, 5'd2);
    tbl[4]  = mkrow(OP_NOP,  5'd0, 5'd0, 5'd0, 1'b0, 6'h3f, 1'b0, 1'b0, 1'b0, 5'd0);
    tbl[5]  = mkrow(OP_NOP,  5'd0, 5'd0, 5'd0, 1'b0, 6'h3f, 1'b0, 1'b0, 1'b1, 5'd3);
    tbl[6]  = mkrow(OP_LW,   5'd1, 5'd2, 5'd0, 1'b0, 6'h3f, 1'b0, 1'b0, 1'b0, 5'd0);
    tbl[7]  = mkrow(OP_ADDI, 5'd5, 5'd2, 5'd0, 1'b0, 6'h23, 1'b0, 1'b0, 1'b0, 5'd0);
    tbl[8]  = mkrow(OP_LW,   5'd1, 5'd0, 5'd0, 1'b0, 6'h08, 1'b0, 1'b1, 1'b0, 5'd0);
    tbl[9]  = mkrow(OP_R,    5'd0, 5'd0, 5'd3, 1'b0, 6'h23, 1'b0, 1'b0, 1'b1, 5'd2);
    tbl[10] = mkrow(OP_NOP,  5'd0, 5'd0, 5'd0, 1'b0, 6'h00, 1'b1, 1'b1, 1'b1, 5'd2);
    tbl[11] = mkrow(OP_NOP,  5'd0, 5'd0, 5'd0, 1'b0, 6'h3f, 1'b0, 1'b0, 1'b0, 5'd0);
    tbl[12] = mkrow(OP_NOP,  5'd0, 5'd0, 5'd0, 1'b0, 6'h3f, 1'b0, 1'b0, 1'b1, 5'd3);

    rst_n = 1'b0;
    opcode_id = OP_NOP; rs_id = '0; rt_id = '0; rd_id = '0; branch_taken_ex = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check($sformatf("reset dut%0d", k), 32'(act[k]), 32'(RST_VEC));
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].rd, 1'b0);
      check($sformatf("table row %0d", i),
            32'({snap[0][19], snap[0][16:11], snap[0][18], snap[0][9], snap[0][7], snap[0][5:1]}),
            32'(tbl[i].exp));
    end

    // reset while LW sits in EX
    step(OP_LW, 5'd1, 5'd6, 5'd0, 1'b0);
    async_reset("reset LW in EX");

    // taken branch: flush, then a bubble in EX
    step(OP_BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
    step(OP_R, 5'd2, 5'd2, 5'd5, 1'b1);
    check("branch flush/stall/pc_write", 32'({snap[0][20], snap[0][19], snap[0][22]}), 32'(3'b101));
    step(OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    check("branch bubble in EX", 32'({snap[0][18], snap[0][16:11]}), 32'd0);

    // single multiply: latency 4 on dut0, latency 1 on dut1
    busy0 = 0; pclow0 = 0; busy1 = 0; arr0 = -1; arr1 = -1;
    for (int i = 0; i < 11; i++) begin
      if (i == 0) step(OP_MUL, 5'd1, 5'd2, 5'd7, 1'b0);
      else        step(OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
      busy0 += int'(snap[0][0]);
      pclow0 += int'(!snap[0][22]);
      busy1 += int'(snap[1][0]);
      if (arr0 < 0 && snap[0][7] && snap[0][5:1] == 5'd7) arr0 = i;
      if (arr1 < 0 && snap[1][7] && snap[1][5:1] == 5'd7) arr1 = i;
    end
    check("mul L4 busy cycles", 32'(busy0), 32'd3);
    check("mul L4 pc_write low", 32'(pclow0), 32'd3);
    check("mul L4 WB arrival", 32'(arr0), 32'd6);
    check("mul L1 busy cycles", 32'(busy1), 32'd0);
    check("mul L1 WB arrival", 32'(arr1), 32'd3);

    // back-to-back multiplies on dut3; the second is re-presented while ID is held
    phase = 0; busy3 = 0;
    for (int i = 0; i < 14; i++) begin
      case (phase)
        0:       step(OP_MUL, 5'd1, 5'd2, 5'd7, 1'b0);
        1:       step(OP_MUL, 5'd1, 5'd2, 5'd8, 1'b0);
        default: step(OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
      endcase
      if (phase == 0) phase = 1;
      else if (phase == 1 && !m_stall[2]) phase = 2;
      busy3 += int'(snap[2][0]);
      if (snap[2][7]) wq.push_back(snap[2][5:1]);
    end
    check("mul pair busy cycles", 32'(busy3), 32'd4);
    check("mul pair write count", 32'(wq.size()), 32'd2);
    if (wq.size() == 2) begin
      check("mul pair first dest", 32'(wq[0]), 32'd7);
      check("mul pair second dest", 32'(wq[1]), 32'd8);
    end

    // reset in the middle of a multiply, then an empty pipe
    step(OP_MUL, 5'd1, 5'd2, 5'd9, 1'b0);
    step(OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    async_reset("reset mid-mul");
    step(OP_R, 5'd1, 5'd1, 5'd4, 1'b0);
    check("after reset no stall", 32'({snap[0][19], snap[0][0], snap[0][22]}), 32'(3'b001));

    for (int i = 0; i < 400; i++) begin
      step(rops[$urandom_range(0, 9)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
